// File: rtl/z80_bus_arbiter.sv
// z80_bus_arbiter
//   Shares the Z80 system bus between the TV80 CPU and NREQ bus masters. It requests the
//   bus from the CPU with nBUSRQ and waits for nBUSAK. It then grants the bus to one master,
//   chosen round robin. The bus goes back to the CPU after every grant, so the CPU runs at
//   least one machine cycle between grants.
//
// Optional feature macro: Z80_ARB_TIMEOUT_EN
//   When defined, a grant is revoked after MAX_HOLD cycles and TIMEOUT pulses for one cycle.
//   When undefined, no hold counter is built, TIMEOUT is tied to 0 and MAX_HOLD is ignored.
//
// Ports
//   CLK        system clock, all logic on posedge
//   CLR        synchronous active-high reset
//   REQ        per-master bus request, held high while the master needs the bus
//   GNT        one-hot registered grant
//   OWNER      index of the granted master, valid while BUS_OWNED=1
//   BUS_OWNED  a master (not the CPU) owns the bus, equals |GNT
//   TIMEOUT    one-cycle pulse when a grant is forcibly revoked
//   nBUSRQ     active-low bus request to the CPU
//   nBUSAK     active-low bus acknowledge from the CPU, already synchronous to CLK
module z80_bus_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                    CLK,
    input  logic                    CLR,
    input  logic [NREQ-1:0]         REQ,
    output logic [NREQ-1:0]         GNT,
    output logic [$clog2(NREQ)-1:0] OWNER,
    output logic                    BUS_OWNED,
    output logic                    TIMEOUT,
    output logic                    nBUSRQ,
    input  logic                    nBUSAK
);

    localparam int unsigned OW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || MAX_HOLD < 2) begin : gen_bad_params
        $error("z80_bus_arbiter: NREQ must be 2..8 and MAX_HOLD must be >= 2");
    end

    typedef enum logic [1:0] {StIdle, StRequest, StGrant, StRelease} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            owned_q, owned_d;
    logic            busrq_n_q, busrq_n_d;
    logic            end_grant;

`ifdef Z80_ARB_TIMEOUT_EN
    localparam int unsigned HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HoldLast = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          timeout_q, timeout_d;
`endif

    logic          any_req;
    logic [OW-1:0] win;
    logic          win_found;
    int unsigned   cand;
    logic [OW:0]   ptr_inc;
    logic [OW-1:0] ptr_after;

    assign any_req = |REQ;

    // Pointer that the next grant search starts from once the current owner lets go.
    assign ptr_inc   = {1'b0, owner_q} + 1'b1;
    assign ptr_after = (32'(ptr_inc) >= NREQ) ? '0 : ptr_inc[OW-1:0];

    // Round-robin search: first set REQ bit at or above rr_ptr, wrapping around.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        cand      = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(rr_ptr_q) + k) % NREQ;
            if (!win_found && REQ[cand[OW-1:0]]) begin
                win_found = 1'b1;
                win       = cand[OW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        owned_d   = owned_q;
        busrq_n_d = busrq_n_q;
        rr_ptr_d  = rr_ptr_q;
        end_grant = 1'b0;
`ifdef Z80_ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d   = StRequest;
                    busrq_n_d = 1'b0;
                end
            end
            StRequest: begin
                if (!nBUSAK && any_req) begin
                    state_d = StGrant;
                    gnt_d   = NREQ'(1) << win;
                    owner_d = win;
                    owned_d = 1'b1;
`ifdef Z80_ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end else if (!any_req) begin
                    // Withdrawn; if the CPU already acknowledged, wait for it to let go.
                    busrq_n_d = 1'b1;
                    state_d   = nBUSAK ? StIdle : StRelease;
                end
            end
            StGrant: begin
                // nBUSAK rising mid-grant is a CPU protocol error, handled as a release.
                if (!REQ[owner_q] || nBUSAK) begin
                    end_grant = 1'b1;
`ifdef Z80_ARB_TIMEOUT_EN
                end else if (hold_cnt_q == HoldLast) begin
                    end_grant = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
`endif
                end
                if (end_grant) begin
                    state_d   = StRelease;
                    gnt_d     = '0;
                    owned_d   = 1'b0;
                    busrq_n_d = 1'b1;
                    rr_ptr_d  = ptr_after;
                end
            end
            StRelease: begin
                if (nBUSAK) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            owner_q   <= '0;
            owned_q   <= 1'b0;
            busrq_n_q <= 1'b1;
            rr_ptr_q  <= '0;
`ifdef Z80_ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            owned_q   <= owned_d;
            busrq_n_q <= busrq_n_d;
            rr_ptr_q  <= rr_ptr_d;
`ifdef Z80_ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign GNT       = gnt_q;
    assign OWNER     = owner_q;
    assign BUS_OWNED = owned_q;
    assign nBUSRQ    = busrq_n_q;
`ifdef Z80_ARB_TIMEOUT_EN
    assign TIMEOUT   = timeout_q;
`else
    assign TIMEOUT   = 1'b0;
`endif

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Self-checking bench for z80_bus_arbiter: directed scenarios plus randomized traffic.
// All outputs are compared every cycle against a transaction-level reference model.
module tb_z80_bus_arbiter;

    localparam int unsigned NREQ     = 4;
    localparam int unsigned MAX_HOLD = 8;
`ifdef Z80_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       CLR;
    logic [3:0] REQ;
    logic [3:0] GNT;
    logic [1:0] OWNER;
    logic       BUS_OWNED;
    logic       TIMEOUT;
    logic       nBUSRQ;
    logic       nBUSAK;

    always #5 CLK = ~CLK;

    z80_bus_arbiter #(
        .NREQ     (NREQ),
        .MAX_HOLD (MAX_HOLD)
    ) u_dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .REQ       (REQ),
        .GNT       (GNT),
        .OWNER     (OWNER),
        .BUS_OWNED (BUS_OWNED),
        .TIMEOUT   (TIMEOUT),
        .nBUSRQ    (nBUSRQ),
        .nBUSAK    (nBUSAK)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: tracks who owns the bus, for how long, and where the search starts.
    localparam int P_IDLE  = 0;  // bus with CPU, nothing asked
    localparam int P_WAIT  = 1;  // asked CPU for the bus
    localparam int P_OWN   = 2;  // a master holds the bus
    localparam int P_DRAIN = 3;  // waiting for the CPU to take the bus back

    int m_phase, m_ptr, m_w, m_held;
    bit m_owned, m_busrq_n, m_timeout;

    function automatic int pick(input logic [3:0] r, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return 0;
    endfunction

    task automatic model_end_grant(input bit to);
        m_owned   = 1'b0;
        m_busrq_n = 1'b1;
        m_ptr     = (m_w + 1) % 4;
        m_phase   = P_DRAIN;
        m_timeout = to;
    endtask

    task automatic model_step(input logic clr, input logic [3:0] req, input logic ak);
        m_timeout = 1'b0;
        if (clr) begin
            m_phase = P_IDLE; m_ptr = 0; m_w = 0; m_held = 0;
            m_owned = 1'b0; m_busrq_n = 1'b1;
        end else begin
            case (m_phase)
                P_IDLE: if (req != 0) begin m_phase = P_WAIT; m_busrq_n = 1'b0; end
                P_WAIT: begin
                    if (req != 0 && !ak) begin
                        m_w = pick(req, m_ptr); m_owned = 1'b1; m_held = 1; m_phase = P_OWN;
                    end else if (req == 0) begin
                        m_busrq_n = 1'b1;
                        m_phase   = ak ? P_IDLE : P_DRAIN;
                    end
                end
                P_OWN: begin
                    if (!req[m_w] || ak) model_end_grant(1'b0);
                    else if (TO_EN && m_held == int'(MAX_HOLD)) model_end_grant(1'b1);
                    else m_held++;
                end
                default: if (ak) m_phase = P_IDLE;
            endcase
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare 1 ns later.
    task automatic tick(input logic clr, input logic [3:0] req, input logic ak);
        logic [3:0] eg;
        CLR = clr; REQ = req; nBUSAK = ak;
        @(posedge CLK);
        model_step(clr, req, ak);
        #1;
        eg = '0;
        if (m_owned) eg[m_w] = 1'b1;
        check_eq("GNT", GNT, eg);
        check_eq("BUS_OWNED", BUS_OWNED, m_owned);
        check_eq("nBUSRQ", nBUSRQ, m_busrq_n);
        check_eq("TIMEOUT", TIMEOUT, m_timeout);
        if (m_owned) check_eq("OWNER", OWNER, m_w);
    endtask

    // CPU model: nBUSAK follows nBUSRQ after a short random delay.
    bit cpu_ak  = 1'b1;
    int cpu_dly = 0;

    task automatic cpu_update();
        if (cpu_ak != nBUSRQ) begin
            if (cpu_dly == 0) begin
                cpu_ak  = nBUSRQ;
                cpu_dly = $urandom_range(0, 2);
            end else begin
                cpu_dly--;
            end
        end
    endtask

    task automatic do_reset();
        tick(1'b1, 4'b0000, 1'b1);
        cpu_ak  = 1'b1;
        cpu_dly = 0;
    endtask

    // Hold req until some grant appears (bounded); returns whether one did.
    task automatic wait_owned(input logic [3:0] req, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            cpu_update();
            tick(1'b0, req, cpu_ak);
            ok = BUS_OWNED;
        end
    endtask

    logic [3:0] rr_exp [5];
    logic [3:0] r;
    int  held, n_gr, run, first_run, to_cnt;
    bit  gap, prev_owned, ended, to_at_end, ok;

    initial begin
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset with all requests high
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 4'b1111, 1'b1);
            check_eq("rst_gnt", GNT, 4'b0000);
            check_eq("rst_busrq", nBUSRQ, 1'b1);
            check_eq("rst_owner", OWNER, 2'd0);
        end
        cpu_ak = 1'b1; cpu_dly = 0;

        // Single grant with fixed CPU latency
        tick(1'b0, 4'b0010, 1'b1);
        check_eq("sg_busrq_low", nBUSRQ, 1'b0);
        tick(1'b0, 4'b0010, 1'b1);
        tick(1'b0, 4'b0010, 1'b1);
        tick(1'b0, 4'b0010, 1'b1);
        tick(1'b0, 4'b0010, 1'b0);
        check_eq("sg_gnt", GNT, 4'b0010);
        check_eq("sg_owner", OWNER, 2'd1);
        tick(1'b0, 4'b0000, 1'b0);
        check_eq("sg_drop_gnt", GNT, 4'b0000);
        check_eq("sg_drop_busrq", nBUSRQ, 1'b1);
        tick(1'b0, 4'b0000, 1'b1);
        tick(1'b0, 4'b0000, 1'b1);

        // Round robin with all masters requesting
        do_reset();
        gap = nBUSRQ; prev_owned = 1'b0; held = 0; n_gr = 0;
        for (int i = 0; i < 200 && n_gr < 5; i++) begin
            cpu_update();
            if (BUS_OWNED) begin
                held++;
                r = (held >= 3) ? (4'hF & ~GNT) : 4'hF;
            end else begin
                held = 0;
                r    = 4'hF;
            end
            tick(1'b0, r, cpu_ak);
            if (nBUSRQ) gap = 1'b1;
            if (BUS_OWNED && !prev_owned) begin
                check_eq("rr_gap", gap, 1'b1);
                check_eq($sformatf("rr_grant%0d", n_gr), GNT, rr_exp[n_gr]);
                n_gr++;
                gap = 1'b0;
            end
            prev_owned = BUS_OWNED;
        end
        check_eq("rr_count", n_gr, 5);

        // Withdrawal before acknowledge
        do_reset();
        tick(1'b0, 4'b0001, 1'b1);
        tick(1'b0, 4'b0000, 1'b1);
        check_eq("wd_busrq", nBUSRQ, 1'b1);
        check_eq("wd_gnt", GNT, 4'b0000);
        for (int i = 0; i < 3; i++) tick(1'b0, 4'b0000, 1'b1);

        // Master that never lets go
        do_reset();
        run = 0; ended = 1'b0; to_at_end = 1'b0; to_cnt = 0; first_run = 0;
        for (int i = 0; i < 130; i++) begin
            cpu_update();
            tick(1'b0, 4'b0100, cpu_ak);
            if (TIMEOUT) to_cnt++;
            if (GNT == 4'b0100) begin
                run++;
            end else if (run > 0 && !ended) begin
                ended = 1'b1; first_run = run; to_at_end = TIMEOUT;
            end
        end
`ifdef Z80_ARB_TIMEOUT_EN
        check_eq("to_ended", ended, 1'b1);
        check_eq("to_len", first_run, MAX_HOLD);
        check_eq("to_pulse", to_at_end, 1'b1);
        check_eq("to_regrant", run > int'(MAX_HOLD), 1'b1);
`else
        check_eq("nto_ended", ended, 1'b0);
        check_eq("nto_long", run >= 100, 1'b1);
        check_eq("nto_gnt", GNT, 4'b0100);
        check_eq("nto_pulses", to_cnt, 0);
`endif

        // Reset in the middle of a grant restarts the round-robin pointer
        do_reset();
        wait_owned(4'b0010, ok);
        check_eq("mid_first", ok, 1'b1);
        for (int i = 0; i < 10 && BUS_OWNED; i++) begin
            cpu_update();
            tick(1'b0, 4'b0000, cpu_ak);
        end
        for (int i = 0; i < 10 && !nBUSAK; i++) begin
            cpu_update();
            tick(1'b0, 4'b0000, cpu_ak);
        end
        wait_owned(4'b1000, ok);
        check_eq("mid_gnt", GNT, 4'b1000);
        tick(1'b1, 4'b1000, cpu_ak);
        check_eq("mid_rst_gnt", GNT, 4'b0000);
        check_eq("mid_rst_busrq", nBUSRQ, 1'b1);
        wait_owned(4'b1111, ok);
        check_eq("mid_ptr0", GNT, 4'b0001);

        // Randomized traffic, occasional CPU glitches and resets
        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 1500; i++) begin
            cpu_update();
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            if ($urandom_range(0, 39) == 0) cpu_ak = ~cpu_ak;
            if ($urandom_range(0, 99) == 0) begin
                tick(1'b1, r, cpu_ak);
            end else begin
                tick(1'b0, r, cpu_ak);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
